// File: rtl/bfly10_stage.sv
// rtl/bfly10_stage.sv - radix-2 butterfly stage 10 of the 16-lane streaming FFT
module bfly10_stage #(
    parameter int IN_WIDTH = 11,
    parameter int WIDTH    = 12,
    parameter int HALF     = 4,
    parameter int LANES    = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       din_valid,
    input  logic signed [IN_WIDTH-1:0] din_re       [0:LANES-1],
    input  logic signed [IN_WIDTH-1:0] din_im       [0:LANES-1],
    output logic                       bfly_valid,
    output logic signed [WIDTH-1:0]    bfly_sum_re  [0:LANES-1],
    output logic signed [WIDTH-1:0]    bfly_sum_im  [0:LANES-1],
    output logic signed [WIDTH-1:0]    bfly_diff_re [0:LANES-1],
    output logic signed [WIDTH-1:0]    bfly_diff_im [0:LANES-1],
    output logic                       bfly_busy
);
    localparam int PW = $clog2(2 * HALF);
    localparam int KW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] HALF_P = PW'(HALF);
    localparam logic [PW-1:0] LAST_P = PW'(2 * HALF - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          valid_q, valid_d;
    logic          fill, combine;
    logic [KW-1:0] wr_idx, rd_idx;

    logic signed [IN_WIDTH-1:0] buf_re_q [0:HALF-1][0:LANES-1];
    logic signed [IN_WIDTH-1:0] buf_im_q [0:HALF-1][0:LANES-1];

    logic signed [WIDTH-1:0] sum_re_q [0:LANES-1], sum_re_d [0:LANES-1];
    logic signed [WIDTH-1:0] sum_im_q [0:LANES-1], sum_im_d [0:LANES-1];
    logic signed [WIDTH-1:0] dif_re_q [0:LANES-1], dif_re_d [0:LANES-1];
    logic signed [WIDTH-1:0] dif_im_q [0:LANES-1], dif_im_d [0:LANES-1];

    function automatic logic signed [WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
        return {{(WIDTH - IN_WIDTH){x[IN_WIDTH-1]}}, x};
    endfunction

    assign fill    = din_valid && (phase_q < HALF_P);
    assign combine = din_valid && (phase_q >= HALF_P);
    assign wr_idx  = KW'(phase_q);
    assign rd_idx  = KW'(phase_q - HALF_P);

    always_comb begin
        phase_d  = phase_q;
        valid_d  = 1'b0;
        sum_re_d = sum_re_q;
        sum_im_d = sum_im_q;
        dif_re_d = dif_re_q;
        dif_im_d = dif_im_q;
        if (din_valid) begin
            phase_d = (phase_q == LAST_P) ? '0 : phase_q + 1'b1;
        end
        if (combine) begin
            valid_d = 1'b1;
            for (int j = 0; j < LANES; j++) begin
                sum_re_d[j] = sext(buf_re_q[rd_idx][j]) + sext(din_re[j]);
                sum_im_d[j] = sext(buf_im_q[rd_idx][j]) + sext(din_im[j]);
                dif_re_d[j] = sext(buf_re_q[rd_idx][j]) - sext(din_re[j]);
                dif_im_d[j] = sext(buf_im_q[rd_idx][j]) - sext(din_im[j]);
            end
        end
    end

    // Entry k is read at phase HALF+k before any later group rewrites it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q <= '0;
            valid_q <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                sum_re_q[j] <= '0;
                sum_im_q[j] <= '0;
                dif_re_q[j] <= '0;
                dif_im_q[j] <= '0;
                for (int k = 0; k < HALF; k++) begin
                    buf_re_q[k][j] <= '0;
                    buf_im_q[k][j] <= '0;
                end
            end
        end else begin
            phase_q  <= phase_d;
            valid_q  <= valid_d;
            sum_re_q <= sum_re_d;
            sum_im_q <= sum_im_d;
            dif_re_q <= dif_re_d;
            dif_im_q <= dif_im_d;
            if (fill) begin
                buf_re_q[wr_idx] <= din_re;
                buf_im_q[wr_idx] <= din_im;
            end
        end
    end

    assign bfly_valid   = valid_q;
    assign bfly_sum_re  = sum_re_q;
    assign bfly_sum_im  = sum_im_q;
    assign bfly_diff_re = dif_re_q;
    assign bfly_diff_im = dif_im_q;
    assign bfly_busy    = (phase_q != '0);
endmodule
